stopwatch_timer_core: RTL

//   Parametrised mixed-radix stopwatch/countdown engine: N cascaded digits, per-digit base, internal tick prescaler.

---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/bcd_digit_cell.sv | 43 ++++
 rtl/stopwatch_timer_core.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch/countdown engine: digit width, FSM states,
// per-digit base extraction and preset saturation.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } sw_state_e;

  // Base of digit idx from the packed 4-bit-per-digit base vector.
  function automatic int unsigned base_of(input logic [31:0] bases, input int unsigned idx);
    logic [31:0] sh;
    sh = bases >> (idx * DIGIT_W);
    return 32'(sh[DIGIT_W-1:0]);
  endfunction

  // Clamp a preset digit so no code at or above its base is ever held.
  function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] v,
                                                    input int unsigned base);
    if (32'(v) >= base) return DIGIT_W'(base - 1);
    return v;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One counter digit of radix BASE; steps when the shared step strobe and its
// carry/borrow-in are both high, wrapping within 0..BASE-1.
module bcd_digit_cell
  import stopwatch_pkg::*;
#(
  parameter int unsigned BASE = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  input  logic               up,
  input  logic               carry_in,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] value,
  output logic               at_max,
  output logic               at_zero
);

  localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(BASE - 1);

  logic [DIGIT_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = sat_digit(load_val, BASE);
    end else if (step && carry_in) begin
      if (up) value_d = (value_q == MAX_V) ? '0 : value_q + DIGIT_W'(1);
      else    value_d = (value_q == '0) ? MAX_V : value_q - DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value   = value_q;
  assign at_max  = (value_q == MAX_V);
  assign at_zero = (value_q == '0);

endmodule

// File: rtl/stopwatch_timer_core.sv
// Mixed-radix stopwatch/countdown: prescaler, run/pause/done FSM and a cascade of digit cells.
// Optional lap-hold display snapshot is built when LAP_HOLD_EN is defined.
module stopwatch_timer_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter logic [31:0] DIGIT_BASES = 32'h0000_6A6A,
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned TICK_HZ     = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          clear,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] load_value,
  input  logic                          up_down,
`ifdef LAP_HOLD_EN
  input  logic                          lap,
`endif
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic                          running,
  output logic                          tick,
  output logic                          wrap,
  output logic                          done
);

  localparam int unsigned W          = NUM_DIGITS * DIGIT_W;
  localparam int unsigned TICK_DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  sw_state_e       state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            running_q, running_d;
  logic            tick_q, tick_d;
  logic            wrap_q, wrap_d;
  logic            done_q, done_d;
  logic            step_c, ld_c;
  logic [W-1:0]    ld_val_c, live_c;
  logic [NUM_DIGITS:0]   cup_c, cdn_c;
  logic [NUM_DIGITS-1:0] at_max_c, at_zero_c;
  logic            all_zero_c, all_max_c, is_one_c;

  // Carry (up) and borrow (down) chains: digit i steps when every lower digit is at its limit.
  assign cup_c[0] = 1'b1;
  assign cdn_c[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_cell #(
      .BASE(base_of(DIGIT_BASES, 32'(i)))
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .step     (step_c),
      .up       (up_down),
      .carry_in (up_down ? cup_c[i] : cdn_c[i]),
      .load     (ld_c),
      .load_val (ld_val_c[i*DIGIT_W +: DIGIT_W]),
      .value    (live_c[i*DIGIT_W +: DIGIT_W]),
      .at_max   (at_max_c[i]),
      .at_zero  (at_zero_c[i])
    );
    assign cup_c[i+1] = cup_c[i] & at_max_c[i];
    assign cdn_c[i+1] = cdn_c[i] & at_zero_c[i];
  end

  assign all_max_c  = cup_c[NUM_DIGITS];
  assign all_zero_c = cdn_c[NUM_DIGITS];
  assign is_one_c   = (live_c == W'(1));

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    tick_d   = 1'b0;
    wrap_d   = 1'b0;
    done_d   = 1'b0;
    step_c   = 1'b0;
    ld_c     = 1'b0;
    ld_val_c = load_value;

    if (clear) begin
      ld_c     = 1'b1;
      ld_val_c = '0;
      state_d  = ST_IDLE;
      presc_d  = '0;
    end else if (load) begin
      ld_c    = 1'b1;
      state_d = ST_IDLE;
      presc_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE:   if (!stop && start && !(!up_down && all_zero_c)) begin
                     state_d = ST_RUN;
                     presc_d = '0;
                   end
        ST_RUN:    if (stop) state_d = ST_PAUSED;
        ST_PAUSED: if (!stop && start) state_d = ST_RUN;
        ST_DONE:   ;
        default:   state_d = ST_IDLE;
      endcase

      // Count step; a down tick already sitting at zero holds rather than wrapping.
      if (state_q == ST_RUN) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          tick_d  = 1'b1;
          step_c  = up_down || !all_zero_c;
          wrap_d  = up_down && all_max_c;
          if (!up_down && is_one_c) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
    end
  end

  assign running = running_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;
  assign done    = done_q;

`ifdef LAP_HOLD_EN
  logic         hold_q, hold_d;
  logic [W-1:0] hold_val_q, hold_val_d;

  // Lap toggles the frozen display; any clear or load releases it.
  always_comb begin
    hold_d     = hold_q;
    hold_val_d = hold_val_q;
    if (clear || load) begin
      hold_d = 1'b0;
    end else if (lap) begin
      hold_d = !hold_q;
      if (!hold_q) hold_val_d = live_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= 1'b0;
      hold_val_q <= '0;
    end else begin
      hold_q     <= hold_d;
      hold_val_q <= hold_val_d;
    end
  end

  assign digits = hold_q ? hold_val_q : live_c;
`else
  assign digits = live_c;
`endif

endmodule
